// File: rtl/seven_seg_scan_decoder_if.sv
// Signal bundle between a scanned four-digit seven-segment display and its
// decoder: active-low scan lines in, published digit codes and status out.
interface seven_seg_scan_decoder_if;
  logic [3:0] digit_in;
  logic [6:0] seg_in;
  logic [3:0] code0;
  logic [3:0] code1;
  logic [3:0] code2;
  logic [3:0] code3;
  logic       disp_valid;
  logic       upd;
  logic       err;
  logic       lost;

  modport master (
    output digit_in, seg_in,
    input  code0, code1, code2, code3, disp_valid, upd, err, lost
  );

  modport slave (
    input  digit_in, seg_in,
    output code0, code1, code2, code3, disp_valid, upd, err, lost
  );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Recovers the four digit codes from a multiplexed active-low seven-segment
// scan and publishes them once enough identical complete frames have been seen.
module seven_seg_scan_decoder #(
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input logic                     clk,
  input logic                     rst,
  seven_seg_scan_decoder_if.slave scan_if
);

  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  BLANK   = 4'd10;
  localparam logic [3:0]  INVALID = 4'd15;
  localparam logic [3:0]  CNT_MAX = 4'd15;

  // Segment pattern (g..a, active low) to digit code.
  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      7'b1000000: code = 4'd0;
      7'b1111001: code = 4'd1;
      7'b0100100: code = 4'd2;
      7'b0110000: code = 4'd3;
      7'b0011001: code = 4'd4;
      7'b0010010: code = 4'd5;
      7'b0000010: code = 4'd6;
      7'b1111000: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0010000: code = 4'd9;
      7'b1111111: code = BLANK;
      default:    code = INVALID;
    endcase
    return code;
  endfunction

  logic [3:0]       dig_q,        dig_prev_q;
  logic [6:0]       seg_q,        seg_prev_q;
  logic             done_q,       done_d;
  logic [3:0][3:0]  shadow_q,     shadow_d;
  logic [3:0]       seen_q,       seen_d;
  logic [3:0][3:0]  prev_frame_q, prev_frame_d;
  logic [3:0]       cnt_q,        cnt_d;
  logic [3:0][3:0]  codes_q,      codes_d;
  logic             valid_q,      valid_d;
  logic [IDLE_W-1:0] idle_q,      idle_d;
  logic             upd_q,        upd_d;
  logic             err_q,        err_d;
  logic             lost_q,       lost_d;

  logic             stable_c;
  logic             act_c;
  logic             capture_c;
  logic             multi_c;
  logic [1:0]       pos_c;
  logic [3:0]       code_c;
  logic [3:0][3:0]  frame_c;
  logic             frame_bad_c;

  // Input sampling and state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q        <= 4'hF;
      seg_q        <= 7'h7F;
      dig_prev_q   <= 4'hF;
      seg_prev_q   <= 7'h7F;
      done_q       <= 1'b0;
      shadow_q     <= {4{BLANK}};
      seen_q       <= 4'h0;
      prev_frame_q <= {4{BLANK}};
      cnt_q        <= 4'd0;
      codes_q      <= {4{BLANK}};
      valid_q      <= 1'b0;
      idle_q       <= '0;
      upd_q        <= 1'b0;
      err_q        <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      dig_q        <= scan_if.digit_in;
      seg_q        <= scan_if.seg_in;
      dig_prev_q   <= dig_q;
      seg_prev_q   <= seg_q;
      done_q       <= done_d;
      shadow_q     <= shadow_d;
      seen_q       <= seen_d;
      prev_frame_q <= prev_frame_d;
      cnt_q        <= cnt_d;
      codes_q      <= codes_d;
      valid_q      <= valid_d;
      idle_q       <= idle_d;
      upd_q        <= upd_d;
      err_q        <= err_d;
      lost_q       <= lost_d;
    end
  end

  // Capture detection, frame assembly, publishing and idle supervision.
  always_comb begin
    done_d       = done_q;
    shadow_d     = shadow_q;
    seen_d       = seen_q;
    prev_frame_d = prev_frame_q;
    cnt_d        = cnt_q;
    codes_d      = codes_q;
    valid_d      = valid_q;
    idle_d       = idle_q;
    upd_d        = 1'b0;
    err_d        = 1'b0;
    lost_d       = lost_q;
    pos_c        = 2'd0;
    code_c       = seg_decode(seg_q);
    frame_c      = shadow_q;
    frame_bad_c  = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (!dig_q[i]) pos_c = 2'(i);
    end

    // A run of identical samples acts once, on its second sample.
    stable_c  = (dig_q == dig_prev_q) && (seg_q == seg_prev_q);
    act_c     = stable_c && !done_q;
    done_d    = stable_c;
    capture_c = act_c && $onehot(~dig_q);
    multi_c   = act_c && (dig_q != 4'hF) && !$onehot(~dig_q);

    if (multi_c) err_d = 1'b1;

    if (capture_c) begin
      idle_d          = '0;
      lost_d          = 1'b0;
      err_d           = (code_c == INVALID);
      frame_c[pos_c]  = code_c;
      shadow_d        = frame_c;
      seen_d          = seen_q | (4'b1 << pos_c);

      if (seen_d == 4'hF) begin
        seen_d = 4'h0;
        for (int i = 0; i < 4; i++) begin
          if (frame_c[i] == INVALID) frame_bad_c = 1'b1;
        end
        if (frame_bad_c) begin
          cnt_d = 4'd0;
        end else if (frame_c == prev_frame_q) begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd1;
        end
        prev_frame_d = frame_c;
        if ((cnt_d >= 4'(STABLE_FRAMES)) && ((frame_c != codes_q) || !valid_q)) begin
          codes_d = frame_c;
          valid_d = 1'b1;
          upd_d   = (frame_c != codes_q);
        end
      end
    end else if (idle_q != IDLE_W'(TIMEOUT)) begin
      idle_d = idle_q + IDLE_W'(1);
      // Scan has gone quiet: drop validity and any partial frame, keep codes.
      if (idle_d == IDLE_W'(TIMEOUT)) begin
        lost_d  = 1'b1;
        valid_d = 1'b0;
        seen_d  = 4'h0;
        cnt_d   = 4'd0;
      end
    end
  end

  assign scan_if.code0      = codes_q[0];
  assign scan_if.code1      = codes_q[1];
  assign scan_if.code2      = codes_q[2];
  assign scan_if.code3      = codes_q[3];
  assign scan_if.disp_valid = valid_q;
  assign scan_if.upd        = upd_q;
  assign scan_if.err        = err_q;
  assign scan_if.lost       = lost_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed scan scenarios plus random scans,
// every cycle compared against a frame-level reference model.
module tb_seven_seg_scan_decoder;

  localparam int unsigned STABLE_FRAMES = 2;
  localparam int unsigned TIMEOUT       = 1024;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seven_seg_scan_decoder_if dut_if ();

  seven_seg_scan_decoder #(
    .STABLE_FRAMES(STABLE_FRAMES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scan_if(dut_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;

  logic [6:0] seg_tab [11];

  // Reference model state.
  int         m_shadow [4];
  int         m_prev   [4];
  int         m_codes  [4];
  bit         m_seen   [4];
  int         m_cnt, m_idle, m_run;
  bit         m_valid, m_lost, m_upd, m_err;
  logic [3:0] m_dig;
  logic [6:0] m_seg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode_ref(input logic [6:0] s);
    for (int i = 0; i < 11; i++) if (seg_tab[i] == s) return i;
    return 15;
  endfunction

  function automatic logic [6:0] seg_of(input int c);
    if (c >= 0 && c <= 10) return seg_tab[c];
    return 7'b0101010;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 10; m_prev[i] = 10; m_codes[i] = 10; m_seen[i] = 0;
    end
    m_cnt = 0; m_idle = 0; m_valid = 0; m_lost = 0; m_upd = 0; m_err = 0;
    m_dig = 4'hF; m_seg = 7'h7F; m_run = 2;
  endtask

  // Effect of one clock edge; (d, s) is the scan value sampled at this edge.
  task automatic model_edge(input logic [3:0] d, input logic [6:0] s);
    int  zeros, p, c;
    bit  cap, bad, same, diff;
    cap = 0; m_upd = 0; m_err = 0;
    if (m_run == 2) begin
      zeros = 4 - $countones(m_dig);
      if (zeros >= 2) m_err = 1;
      else if (zeros == 1) begin
        p = 0;
        for (int i = 0; i < 4; i++) if (!m_dig[i]) p = i;
        c = decode_ref(m_seg);
        cap = 1;
        m_err = (c == 15);
        m_shadow[p] = c;
        m_seen[p] = 1;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
          bad = 0; same = 1; diff = 0;
          for (int i = 0; i < 4; i++) begin
            m_seen[i] = 0;
            if (m_shadow[i] == 15) bad = 1;
            if (m_shadow[i] != m_prev[i]) same = 0;
            if (m_shadow[i] != m_codes[i]) diff = 1;
          end
          if (bad) m_cnt = 0;
          else if (same) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
          else m_cnt = 1;
          for (int i = 0; i < 4; i++) m_prev[i] = m_shadow[i];
          if (m_cnt >= STABLE_FRAMES && (diff || !m_valid)) begin
            for (int i = 0; i < 4; i++) m_codes[i] = m_shadow[i];
            m_valid = 1;
            m_upd = diff;
          end
        end
      end
    end
    if (cap) begin
      m_idle = 0; m_lost = 0;
    end else if (m_idle < TIMEOUT) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_lost = 1; m_valid = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_seen[i] = 0;
      end
    end
    if (d == m_dig && s == m_seg) begin
      if (m_run < 3) m_run++;
    end else begin
      m_run = 1; m_dig = d; m_seg = s;
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_codes, got_codes;
    exp_codes = {4'(m_codes[3]), 4'(m_codes[2]), 4'(m_codes[1]), 4'(m_codes[0])};
    got_codes = {dut_if.code3, dut_if.code2, dut_if.code1, dut_if.code0};
    check_eq("codes", 32'(got_codes), 32'(exp_codes));
    check_eq("disp_valid", 32'(dut_if.disp_valid), 32'(m_valid));
    check_eq("upd", 32'(dut_if.upd), 32'(m_upd));
    check_eq("err", 32'(dut_if.err), 32'(m_err));
    check_eq("lost", 32'(dut_if.lost), 32'(m_lost));
    if (dut_if.upd === 1'b1) upd_cnt++;
    if (dut_if.err === 1'b1) err_cnt++;
  endtask

  // Called at a falling edge; drives, lets one rising edge pass, then checks.
  task automatic step(input logic [3:0] d, input logic [6:0] s);
    dut_if.digit_in = d;
    dut_if.seg_in   = s;
    @(posedge clk);
    model_edge(d, s);
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(d, s);
  endtask

  task automatic scan_frame(input int c0, input int c1, input int c2, input int c3,
                            input int hold_n, input bit rev);
    int c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = rev ? 3 - k : k;
      hold(~(4'b1 << p), seg_of(c[p]), hold_n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq("rst_codes", 32'({dut_if.code3, dut_if.code2, dut_if.code1, dut_if.code0}), 32'h0000_AAAA);
    check_eq("rst_valid", 32'(dut_if.disp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] codes_now();
    return {dut_if.code3, dut_if.code2, dut_if.code1, dut_if.code0};
  endfunction

  initial begin
    int mark_u, mark_e;
    int base [4];

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9] = 7'b0010000; seg_tab[10] = 7'b1111111;

    rst = 1'b1;
    dut_if.digit_in = 4'hF;
    dut_if.seg_in   = 7'h7F;
    model_reset();
    @(negedge clk);
    check_all();
    check_eq("reset_codes", 32'(codes_now()), 32'h0000_AAAA);
    rst = 1'b0;

    // First frame alone must not publish; the second identical one does.
    mark_u = upd_cnt;
    scan_frame(4, 10, 10, 7, 3, 0);
    check_eq("frame1_no_upd", 32'(upd_cnt - mark_u), 32'd0);
    check_eq("frame1_invalid", 32'(dut_if.disp_valid), 32'd0);
    scan_frame(4, 10, 10, 7, 3, 0);
    check_eq("frame2_upd", 32'(upd_cnt - mark_u), 32'd1);
    check_eq("frame2_codes", 32'(codes_now()), 32'h0000_7AA4);
    check_eq("frame2_valid", 32'(dut_if.disp_valid), 32'd1);

    mark_u = upd_cnt;
    for (int i = 0; i < 5; i++) scan_frame(4, 10, 10, 7, 3, 0);
    check_eq("repeat_no_upd", 32'(upd_cnt - mark_u), 32'd0);
    scan_frame(9, 10, 10, 7, 3, 0);
    check_eq("change_wait", 32'(upd_cnt - mark_u), 32'd0);
    scan_frame(9, 10, 10, 7, 3, 0);
    check_eq("change_upd", 32'(upd_cnt - mark_u), 32'd1);
    check_eq("change_codes", 32'(codes_now()), 32'h0000_7AA9);

    // Invalid segment pattern at position 2.
    mark_u = upd_cnt; mark_e = err_cnt;
    scan_frame(9, 10, 15, 7, 3, 0);
    check_eq("bad_seg_err", 32'(err_cnt - mark_e), 32'd1);
    check_eq("bad_seg_held", 32'(codes_now()), 32'h0000_7AA9);
    scan_frame(1, 2, 3, 4, 3, 0);
    scan_frame(1, 2, 3, 4, 3, 0);
    check_eq("clean_upd", 32'(upd_cnt - mark_u), 32'd1);
    check_eq("clean_codes", 32'(codes_now()), 32'h0000_4321);

    // Two digits selected at once, then a scan that never settles.
    mark_e = err_cnt;
    hold(4'b1100, seg_of(5), 3);
    check_eq("multi_err", 32'(err_cnt - mark_e), 32'd1);
    for (int i = 0; i < TIMEOUT + 8; i++) step((i % 2 == 0) ? 4'b1110 : 4'b1101, seg_of(i % 10));
    check_eq("lost_set", 32'(dut_if.lost), 32'd1);
    check_eq("lost_valid", 32'(dut_if.disp_valid), 32'd0);
    check_eq("lost_codes", 32'(codes_now()), 32'h0000_4321);

    // Reverse scan with an overwritten position mid-frame.
    mark_u = upd_cnt; mark_e = err_cnt;
    for (int f = 0; f < 2; f++) begin
      hold(4'b0111, seg_of(5), 3);
      hold(4'b1011, seg_of(6), 3);
      hold(4'b1011, seg_of(0), 1);
      hold(4'b1011, seg_of(8), 3);
      hold(4'b1101, seg_of(0), 3);
      hold(4'b1110, seg_of(3), 3);
    end
    check_eq("rev_upd", 32'(upd_cnt - mark_u), 32'd1);
    check_eq("rev_no_err", 32'(err_cnt - mark_e), 32'd0);
    check_eq("rev_codes", 32'(codes_now()), 32'h0000_5803);
    check_eq("rev_lost_clr", 32'(dut_if.lost), 32'd0);

    // Reset part way through a frame.
    hold(4'b1110, seg_of(1), 3);
    hold(4'b1101, seg_of(1), 3);
    hold(4'b1011, seg_of(1), 3);
    do_reset();
    mark_u = upd_cnt;
    scan_frame(4, 10, 10, 7, 3, 0);
    check_eq("post_rst_f1", 32'(upd_cnt - mark_u), 32'd0);
    scan_frame(4, 10, 10, 7, 3, 0);
    check_eq("post_rst_f2", 32'(upd_cnt - mark_u), 32'd1);

    // Random scans, glitches and occasional resets.
    for (int i = 0; i < 4; i++) base[i] = $urandom_range(0, 10);
    for (int it = 0; it < 250; it++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 2) begin
        do_reset();
      end else if (kind < 10) begin
        hold(4'($urandom), 7'($urandom), $urandom_range(1, 4));
      end else begin
        if ($urandom_range(0, 5) == 0) base[$urandom_range(0, 3)] = $urandom_range(0, 10);
        for (int p = 0; p < 4; p++) begin
          int c;
          c = ($urandom_range(0, 29) == 0) ? 15 : base[p];
          hold(~(4'b1 << p), seg_of(c), $urandom_range(1, 4));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
